// File: rtl/twofish_pkg.sv
// Shared constants, FSM encoding and the Twofish q0/q1 byte permutations.
package twofish_pkg;

  localparam int unsigned KEY_W       = 128;
  localparam int unsigned SK_W        = 32;
  localparam int unsigned NUM_PAIRS   = 20;
  localparam int unsigned NUM_SUBKEYS = 40;
  localparam int unsigned IDX_W       = 5;
  localparam int unsigned ADDR_W      = 6;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_GEN  = 2'd1;
  localparam logic [1:0] ST_PIPE = 2'd2;
  localparam logic [1:0] ST_DONE = 2'd3;

  typedef enum logic [1:0] {
    IDLE = ST_IDLE,
    GEN  = ST_GEN,
    PIPE = ST_PIPE,
    DONE = ST_DONE
  } state_t;

  // 4-bit t-tables, entry 0 in the most significant nibble
  localparam logic [63:0] Q0_T0 = 64'h817D6F320B59ECA4;
  localparam logic [63:0] Q0_T1 = 64'hECB81235F4A6709D;
  localparam logic [63:0] Q0_T2 = 64'hBA5E6D90C8F32471;
  localparam logic [63:0] Q0_T3 = 64'hD7F4126E9B3085CA;
  localparam logic [63:0] Q1_T0 = 64'h28BDF76E31940AC5;
  localparam logic [63:0] Q1_T1 = 64'h1E2B4C376DA5F908;
  localparam logic [63:0] Q1_T2 = 64'h4C75169A0ED82B3F;
  localparam logic [63:0] Q1_T3 = 64'hB951C3DE647F208A;

  function automatic logic [3:0] nib(input logic [63:0] t, input logic [3:0] n);
    return t[{~n, 2'b00} +: 4];
  endfunction

  function automatic logic [3:0] ror4(input logic [3:0] x);
    return {x[0], x[3:1]};
  endfunction

  // s=0 selects q0, s=1 selects q1
  function automatic logic [7:0] qperm(input logic s, input logic [7:0] x);
    logic [3:0] a0, b0, a1, b1, a2, b2, a3, b3, a4, b4;
    a0 = x[7:4];
    b0 = x[3:0];
    a1 = a0 ^ b0;
    b1 = a0 ^ ror4(b0) ^ {a0[0], 3'b000};
    a2 = nib(s ? Q1_T0 : Q0_T0, a1);
    b2 = nib(s ? Q1_T1 : Q0_T1, b1);
    a3 = a2 ^ b2;
    b3 = a2 ^ ror4(b2) ^ {a2[0], 3'b000};
    a4 = nib(s ? Q1_T2 : Q0_T2, a3);
    b4 = nib(s ? Q1_T3 : Q0_T3, b3);
    return {b4, a4};
  endfunction

endpackage

// File: rtl/twofish_subkey_sched_h.sv
// H_Function: 128-bit key and pair index i -> round subkeys K[2i], K[2i+1].
// Key bytes are taken in string order, m0 = key[127:120].
module twofish_subkey_sched_h
  import twofish_pkg::*;
(
  input  logic [KEY_W-1:0] key,
  input  logic [5:0]       pair,
  output logic [SK_W-1:0]  k0,
  output logic [SK_W-1:0]  k1
);

  function automatic logic [7:0] xtime(input logic [7:0] x);
    return {x[6:0], 1'b0} ^ (x[7] ? 8'h69 : 8'h00);
  endfunction

  // GF(2^8) multiply modulo x^8+x^6+x^5+x^3+1
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, aa;
    p  = 8'h00;
    aa = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ aa;
      aa = xtime(aa);
    end
    return p;
  endfunction

  function automatic logic [31:0] bswap(input logic [31:0] x);
    return {x[7:0], x[15:8], x[23:16], x[31:24]};
  endfunction

  function automatic logic [31:0] hfn(input logic [7:0] x, input logic [31:0] l0,
                                      input logic [31:0] l1);
    logic [7:0] y0, y1, y2, y3, z0, z1, z2, z3;
    y0 = qperm(1'b1, qperm(1'b0, qperm(1'b0, x) ^ l1[7:0])   ^ l0[7:0]);
    y1 = qperm(1'b0, qperm(1'b0, qperm(1'b1, x) ^ l1[15:8])  ^ l0[15:8]);
    y2 = qperm(1'b1, qperm(1'b1, qperm(1'b0, x) ^ l1[23:16]) ^ l0[23:16]);
    y3 = qperm(1'b0, qperm(1'b1, qperm(1'b1, x) ^ l1[31:24]) ^ l0[31:24]);
    z0 = y0 ^ gmul(y1, 8'hEF) ^ gmul(y2, 8'h5B) ^ gmul(y3, 8'h5B);
    z1 = gmul(y0, 8'h5B) ^ gmul(y1, 8'hEF) ^ gmul(y2, 8'hEF) ^ y3;
    z2 = gmul(y0, 8'hEF) ^ gmul(y1, 8'h5B) ^ y2 ^ gmul(y3, 8'hEF);
    z3 = gmul(y0, 8'hEF) ^ y1 ^ gmul(y2, 8'hEF) ^ gmul(y3, 8'h5B);
    return {z3, z2, z1, z0};
  endfunction

  logic [31:0] m0, m1, m2, m3, a, b_raw, b, t;

  always_comb begin
    m0    = bswap(key[127:96]);
    m1    = bswap(key[95:64]);
    m2    = bswap(key[63:32]);
    m3    = bswap(key[31:0]);
    a     = hfn({1'b0, pair, 1'b0}, m0, m2);
    b_raw = hfn({1'b0, pair, 1'b1}, m1, m3);
    b     = {b_raw[23:0], b_raw[31:24]};
    t     = a + {b[30:0], 1'b0};
    k0    = a + b;
    k1    = {t[22:0], t[31:23]};
  end

endmodule

// File: rtl/twofish_subkey_sched.sv
// Twofish subkey scheduler: generates K[0..39] into a buffer and serves a registered read port.
// Optional build macro H_PIPE_EN registers the H_Function outputs before the buffer write.
module twofish_subkey_sched
  import twofish_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [KEY_W-1:0]  key_in,
  output logic              busy,
  output logic              done,
  output logic              sk_valid,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [SK_W-1:0]   rd_data
);

  state_t            state, state_d;
  logic [IDX_W-1:0]  idx, idx_d;
  logic [KEY_W-1:0]  key_q, key_d;
  logic              busy_d, done_d, skv_d;
  logic [SK_W-1:0]   h_k0, h_k1;
  logic              wr_en;
  logic [IDX_W-1:0]  wr_idx;
  logic [SK_W-1:0]   wr_k0, wr_k1;
  logic [SK_W-1:0]   sk_buf [NUM_SUBKEYS];

  twofish_subkey_sched_h u_h (
    .key  (key_q),
    .pair ({1'b0, idx}),
    .k0   (h_k0),
    .k1   (h_k1)
  );

`ifdef H_PIPE_EN
  logic             p_vld;
  logic [IDX_W-1:0] p_idx;
  logic [SK_W-1:0]  p_k0, p_k1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      p_vld <= 1'b0;
      p_idx <= '0;
      p_k0  <= '0;
      p_k1  <= '0;
    end else begin
      p_vld <= (state == GEN);
      p_idx <= idx;
      p_k0  <= h_k0;
      p_k1  <= h_k1;
    end
  end

  assign wr_en  = p_vld;
  assign wr_idx = p_idx;
  assign wr_k0  = p_k0;
  assign wr_k1  = p_k1;
`else
  assign wr_en  = (state == GEN);
  assign wr_idx = idx;
  assign wr_k0  = h_k0;
  assign wr_k1  = h_k1;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      idx      <= '0;
      key_q    <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      sk_valid <= 1'b0;
    end else begin
      state    <= state_d;
      idx      <= idx_d;
      key_q    <= key_d;
      busy     <= busy_d;
      done     <= done_d;
      sk_valid <= skv_d;
    end
  end

  // Next-state: start is honoured only in IDLE/DONE; idx holds at the last pair
  always_comb begin
    state_d = state;
    idx_d   = idx;
    key_d   = key_q;
    busy_d  = busy;
    done_d  = 1'b0;
    skv_d   = sk_valid;
    case (state)
      IDLE, DONE: begin
        if (start) begin
          key_d   = key_in;
          idx_d   = '0;
          skv_d   = 1'b0;
          busy_d  = 1'b1;
          state_d = GEN;
        end
      end
      GEN: begin
        if (idx == IDX_W'(NUM_PAIRS - 1)) begin
`ifdef H_PIPE_EN
          state_d = PIPE;
`else
          state_d = DONE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          skv_d   = 1'b1;
`endif
        end else begin
          idx_d = idx + IDX_W'(1);
        end
      end
      PIPE: begin
        state_d = DONE;
        busy_d  = 1'b0;
        done_d  = 1'b1;
        skv_d   = 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

  // Buffer is not reset; sk_valid masks stale contents
  always_ff @(posedge clk) begin
    if (wr_en) begin
      sk_buf[{wr_idx, 1'b0}] <= wr_k0;
      sk_buf[{wr_idx, 1'b1}] <= wr_k1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_data <= '0;
    end else if (sk_valid && (rd_addr < ADDR_W'(NUM_SUBKEYS))) begin
      rd_data <= sk_buf[rd_addr];
    end else begin
      rd_data <= '0;
    end
  end

endmodule
